// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds operation encodings, FSM state encoding, HI/LO move-select constants
// and small decode helpers used by the top and the iteration core.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_e;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_iter_core.sv
// Iteration datapath: 2*NBits accumulator, iteration counter and one
// shift-add (multiply) or restoring shift-subtract (divide) step per i_step.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_load       load magnitudes and clear the counter
//   i_step       perform one iteration
//   i_is_div     1 selects divide step, 0 multiply step
//   i_a, i_b     unsigned multiplicand/dividend and multiplier/divisor
//   o_acc        accumulator: product, or {remainder, quotient}
//   o_last_c     high while the counter is at the final iteration
module mult_div_iter_core #(
  parameter int unsigned NBits = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_is_div,
  input  logic [NBits-1:0]     i_a,
  input  logic [NBits-1:0]     i_b,
  output logic [2*NBits-1:0]   o_acc,
  output logic                 o_last_c
);

  localparam int unsigned AW = 2 * NBits;
  localparam int unsigned CW = $clog2(NBits + 1);

  logic [AW-1:0]    r_acc;
  logic [NBits-1:0] r_m;
  logic [CW-1:0]    r_count;

  logic [NBits:0]   w_sum;
  logic [NBits:0]   w_part;
  logic [NBits:0]   w_diff;
  logic             w_ge;
  logic [AW-1:0]    w_acc_nxt;

  // One iteration. Multiply adds the multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set, then shifts right with carry.
  // Divide shifts the next dividend bit into the partial remainder and keeps
  // the subtraction only when it does not go negative.
  always_comb begin
    w_sum     = {1'b0, r_acc[AW-1:NBits]} + {1'b0, r_m};
    w_part    = {r_acc[AW-1:NBits], r_acc[NBits-1]};
    w_diff    = w_part - {1'b0, r_m};
    w_ge      = (w_part >= {1'b0, r_m});
    w_acc_nxt = r_acc;
    if (i_is_div) begin
      if (w_ge) begin
        w_acc_nxt = {w_diff[NBits-1:0], r_acc[NBits-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_part[NBits-1:0], r_acc[NBits-2:0], 1'b0};
      end
    end else begin
      if (r_acc[0]) begin
        w_acc_nxt = {w_sum, r_acc[NBits-1:1]};
      end else begin
        w_acc_nxt = {1'b0, r_acc[AW-1:1]};
      end
    end
  end

  // Accumulator, operand and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_m     <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_acc   <= {NBits'(0), i_a};
      r_m     <= i_b;
      r_count <= '0;
    end else if (i_step) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CW'(1);
    end
  end

  assign o_acc    = r_acc;
  assign o_last_c = (r_count == CW'(NBits - 1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// MTHI/MTLO move writes and a combinational MFHI/MFLO read port.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   Start, Op            launch an operation (sampled in IDLE only)
//   OperandA, OperandB   rs / rt operands
//   MoveEnable           MTHI/MTLO strobe (IDLE only, loses to Start)
//   MoveSelector         0 writes LO, 1 writes HI
//   MoveData             move write data
//   ReadSelector         0 reads LO, 1 reads HI onto Result
//   Result               combinational HI/LO read value
//   HI, LO               registered architectural registers
//   Busy                 operation in flight
//   Done                 one-cycle pulse once HI/LO hold the result
//   DivByZero            one-cycle pulse with Done on a zero divisor
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [NBits-1:0] OperandA,
  input  logic [NBits-1:0] OperandB,
  input  logic             MoveEnable,
  input  logic             MoveSelector,
  input  logic [NBits-1:0] MoveData,
  input  logic             ReadSelector,
  output logic [NBits-1:0] Result,
  output logic [NBits-1:0] HI,
  output logic [NBits-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned AW = 2 * NBits;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;

  op_e              r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [NBits-1:0] r_orig_a;

  logic [NBits-1:0] r_hi;
  logic [NBits-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  op_e              w_op_in;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [NBits-1:0] w_abs_a;
  logic [NBits-1:0] w_abs_b;
  logic             w_is_div;
  logic [AW-1:0]    w_acc;
  logic             w_last;
  logic [AW-1:0]    w_prod;
  logic [NBits-1:0] w_quo;
  logic [NBits-1:0] w_rem;
  logic [NBits-1:0] w_hi_fin;
  logic [NBits-1:0] w_lo_fin;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_finish    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes for signed ops; the most negative value maps onto
  // itself, which is the correct unsigned magnitude.
  always_comb begin
    w_op_in  = op_e'(Op);
    w_sign_a = op_is_signed(w_op_in) & OperandA[NBits-1];
    w_sign_b = op_is_signed(w_op_in) & OperandB[NBits-1];
    w_abs_a  = w_sign_a ? NBits'(-OperandA) : OperandA;
    w_abs_b  = w_sign_b ? NBits'(-OperandB) : OperandB;
  end

  // Operation context captured at Start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_MULT;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_orig_a <= '0;
    end else if (w_load) begin
      r_op     <= w_op_in;
      r_neg_q  <= w_sign_a ^ w_sign_b;
      r_neg_r  <= w_sign_a;
      r_div0   <= op_is_div(w_op_in) && (OperandB == '0);
      r_orig_a <= OperandA;
    end
  end

  assign w_is_div = op_is_div(r_op);

  mult_div_iter_core #(
    .NBits (NBits)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_a      (w_abs_a),
    .i_b      (w_abs_b),
    .o_acc    (w_acc),
    .o_last_c (w_last)
  );

  // Sign correction and divide-by-zero override applied in FINISH.
  always_comb begin
    w_prod   = r_neg_q ? AW'(-w_acc) : w_acc;
    w_quo    = w_acc[NBits-1:0];
    w_rem    = w_acc[AW-1:NBits];
    w_hi_fin = w_prod[AW-1:NBits];
    w_lo_fin = w_prod[NBits-1:0];
    if (w_is_div) begin
      if (r_div0) begin
        w_hi_fin = r_orig_a;
        w_lo_fin = '1;
      end else begin
        w_hi_fin = r_neg_r ? NBits'(-w_rem) : w_rem;
        w_lo_fin = r_neg_q ? NBits'(-w_quo) : w_quo;
      end
    end
  end

  // HI/LO and status registers; moves only land in IDLE when Start is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_dz   <= w_finish & r_div0;
      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
      if (w_finish) begin
        r_hi <= w_hi_fin;
        r_lo <= w_lo_fin;
      end else if ((r_state == IDLE) && !Start && MoveEnable) begin
        if (MoveSelector == SEL_HI) begin
          r_hi <= MoveData;
        end else begin
          r_lo <= MoveData;
        end
      end
    end
  end

  assign HI        = r_hi;
  assign LO        = r_lo;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dz;
  assign Result    = (ReadSelector == SEL_HI) ? r_hi : r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS pipeline.
- Sits directly upstream of the write-back 3-to-1 select; its HI/LO read value is the third data input (ALU result, memory data, HI/LO).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake.
- Also services MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- NBits, 32, operand and HI/LO width; the iteration count equals NBits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- OperandA  input  NBits  multiplicand / dividend (rs)
- OperandB  input  NBits  multiplier / divisor (rt)
- MoveEnable  input  1  MTHI/MTLO write strobe
- MoveSelector  input  1  0 writes LO, 1 writes HI
- MoveData  input  NBits  data for MTHI/MTLO
- ReadSelector  input  1  0 selects LO, 1 selects HI onto Result
- Result  output  NBits  combinational HI or LO (MFHI/MFLO value)
- HI  output  NBits  registered HI
- LO  output  NBits  registered LO
- Busy  output  1  high while an operation is in flight
- Done  output  1  one-cycle pulse when HI/LO have been updated
- DivByZero  output  1  one-cycle pulse, coincident with Done, for DIV/DIVU with OperandB==0

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: HI=0, LO=0, Busy=0, Done=0, DivByZero=0, state=IDLE.
- Reset asserted mid-operation aborts the operation; no Done pulse is produced.

- State IDLE:
  - Start=1 at edge E0 latches Op, |A| and |B| (signed ops), the result signs, and Count=0, then goes to RUN.
  - Busy=1 from E0 onward.
- State RUN:
  - One iteration per edge, E1..E32.
  - Multiply: shift-add into a 2*NBits accumulator.
  - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
  - After the iteration where Count==NBits-1 (edge E32), go to FINISH.
- State FINISH (edge E33):
  - Apply sign correction and write HI/LO.
  - Done=1, Busy=0, return to IDLE.
  - Done is high for exactly the cycle after E33; HI/LO already hold the new values in that cycle.
- Latency: 33 clocks from the Start sample to Done. Start is accepted again in the same cycle Done is high.

- Multiply result: HI:LO = 64-bit product.
  - MULT: product negated if sign(A) XOR sign(B).
  - MULTU: unsigned product.
- Divide result: LO = quotient, HI = remainder.
  - DIV quotient sign = sign(A) XOR sign(B).
  - DIV remainder sign = sign(A); quotient truncates toward zero.
  - DIVU: unsigned quotient and remainder.
- Divide by zero, both DIV and DIVU:
  - LO = all ones, HI = original OperandA, DivByZero pulses with Done.
  - Timing is still the full 33 cycles.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, no flag.

- Move writes:
  - In IDLE, MoveEnable=1 writes MoveData to the register named by MoveSelector at the next edge.
  - Move writes are ignored while Busy.
  - Start and MoveEnable together in IDLE: Start wins and the move is dropped.
- Start while Busy is ignored; operands are not re-latched.
- Operand inputs may change freely after the Start sample.
- Result = ReadSelector ? HI : LO, combinational. During Busy it shows the pre-operation values; the pipeline stalls on Busy.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: IDLE, RUN, FINISH.
  - Move select constants: SEL_LO=0, SEL_HI=1.
- One sub-module, mult_div_iter_core: holds the accumulator, Count and one shift-add/shift-subtract step per enable.
- The top holds the FSM, sign handling, HI/LO registers and the read select.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> Done exactly 33 cycles after Start, HI=0xFFFFFFFE, LO=0x00000001, Busy high for cycles 1..33.
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, DivByZero and Done high in the same single cycle.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero=0.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A in IDLE -> ReadSelector=1 gives Result=0xA5A5A5A5, 0 gives 0x5A5A5A5A.
  - MTLO issued while Busy -> LO unchanged.
  - Second Start during Busy -> ignored.
- reset asserted at cycle 10 of a MULT -> next cycle HI=LO=0, Busy=0, no Done.
  - New Start issued right after reset -> normal 33-cycle completion.
